// File: rtl/cache_ctl.sv
// Direct-mapped write-through byte cache controller: tag/valid state, bank port, byte-wise line fill.
// Read hit resp 3 cycles after accept; memory waits held until mem_ack; req_ready only in IDLE.
module cache_ctl #(
  parameter int ADDR_W     = 16,
  parameter int CACHE_SIZE = 32768,
  parameter int LINE_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              resp_valid,
  output logic [7:0]        resp_rdata,
  input  logic              inv_all,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_we,
  output logic [7:0]        cache_data_in,
  input  logic [7:0]        cache_data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);
  localparam int IDX_W  = $clog2(CACHE_SIZE);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LIDX_W = IDX_W - OFF_W;
  localparam int TAG_W  = ADDR_W - IDX_W;
  localparam int NLINES = CACHE_SIZE / LINE_BYTES;
  localparam logic [OFF_W-1:0] LAST_K = OFF_W'(LINE_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, RD_WAIT, RESP, WR_BANK, WT_MEM, FILL_REQ, FILL_ADDR, FILL_WR
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [7:0]          wdata_q;
  logic [7:0]          fill_q;
  logic [OFF_W-1:0]    k_q;
  logic [NLINES-1:0]   valid_q;
  logic [TAG_W-1:0]    tag_mem [NLINES];

  logic [LIDX_W-1:0]   line;
  logic [TAG_W-1:0]    tag;
  logic [ADDR_W-1:0]   fill_addr;
  logic                hit;
  logic                accept;

  assign line      = addr_q[IDX_W-1:OFF_W];
  assign tag       = addr_q[ADDR_W-1:IDX_W];
  assign fill_addr = {addr_q[ADDR_W-1:OFF_W], k_q};
  assign hit       = valid_q[line] && (tag_mem[line] == tag);
  assign req_ready = (state == IDLE) && !inv_all && rst_n;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      fill_q  <= '0;
      k_q     <= '0;
      valid_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      if (state == IDLE && inv_all)
        valid_q <= '0;
      if (state == LOOKUP)
        k_q <= '0;
      if (state == FILL_REQ && mem_ack)
        fill_q <= mem_rdata;
      // Line only becomes valid once its last byte is in the bank.
      if (state == FILL_WR) begin
        if (k_q == LAST_K) begin
          k_q           <= '0;
          valid_q[line] <= 1'b1;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL_WR && k_q == LAST_K)
      tag_mem[line] <= tag;
  end

  always_comb begin
    state_nxt     = state;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    cache_addr    = '0;
    cache_we      = 1'b0;
    cache_data_in = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state)
      IDLE: if (accept) state_nxt = LOOKUP;
      LOOKUP: begin
        cache_addr = addr_q;
        if (we_q) state_nxt = hit ? WR_BANK : WT_MEM;
        else      state_nxt = hit ? RD_WAIT : FILL_REQ;
      end
      RD_WAIT: begin
        cache_addr = addr_q;
        state_nxt  = RESP;
      end
      RESP: begin
        cache_addr = addr_q;
        resp_valid = 1'b1;
        resp_rdata = we_q ? 8'h00 : cache_data_out;
        state_nxt  = IDLE;
      end
      WR_BANK: begin
        cache_addr    = addr_q;
        cache_we      = 1'b1;
        cache_data_in = wdata_q;
        state_nxt     = WT_MEM;
      end
      WT_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) state_nxt = RESP;
      end
      FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = fill_addr;
        if (mem_ack) state_nxt = FILL_ADDR;
      end
      FILL_ADDR: begin
        cache_addr = fill_addr;
        state_nxt  = FILL_WR;
      end
      FILL_WR: begin
        cache_addr    = fill_addr;
        cache_we      = 1'b1;
        cache_data_in = fill_q;
        state_nxt     = (k_q == LAST_K) ? LOOKUP : FILL_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
